// File: rtl/cc_meta_pkg.sv
// Shared card-metadata definitions: classifier codes, ASCII record alphabet,
// record lengths and the byte generator used by the metadata record transmitter.
package cc_meta_pkg;

  // Brand codes published by the IIN prefix classifier
  localparam logic [2:0] BRAND_NONE     = 3'd0;
  localparam logic [2:0] BRAND_VISA     = 3'd1;
  localparam logic [2:0] BRAND_MC       = 3'd2;
  localparam logic [2:0] BRAND_AMEX     = 3'd3;
  localparam logic [2:0] BRAND_DISCOVER = 3'd4;
  localparam logic [2:0] BRAND_JCB      = 3'd5;

  // Issuer codes (5-bit space, only a few named here)
  localparam logic [4:0] ISS_UNKNOWN    = 5'd0;
  localparam logic [4:0] ISS_GENERIC    = 5'd1;

  // Card type codes
  localparam logic [1:0] TYPE_CREDIT    = 2'd0;
  localparam logic [1:0] TYPE_DEBIT     = 2'd1;
  localparam logic [1:0] TYPE_PREPAID   = 2'd2;
  localparam logic [1:0] TYPE_UNKNOWN   = 2'd3;

  // ASCII alphabet of the record
  localparam logic [7:0] ASC_V  = 8'h56;
  localparam logic [7:0] ASC_I  = 8'h49;
  localparam logic [7:0] ASC_H  = 8'h48;
  localparam logic [7:0] ASC_M  = 8'h4D;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  // Record lengths without the optional CR
  localparam logic [3:0] REC_LEN_VALID   = 4'd7;
  localparam logic [3:0] REC_LEN_INVALID = 4'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic       valid;
    logic       hit;
    logic [2:0] brand;
    logic [4:0] issuer;
    logic [1:0] type_id;
  } meta_snap_t;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    logic [7:0] h;
    if (n < 4'd10) begin
      h = ASC_0 + {4'd0, n};
    end else begin
      h = ASC_A + ({4'd0, n} - 8'd10);
    end
    return h;
  endfunction

  // Total record length including the line ending
  function automatic logic [3:0] meta_rec_len(input meta_snap_t s, input logic eol_crlf);
    logic [3:0] len;
    if (s.valid) begin
      len = REC_LEN_VALID + {3'd0, eol_crlf};
    end else begin
      len = REC_LEN_INVALID + {3'd0, eol_crlf};
    end
    return len;
  endfunction

  // Byte at position idx of the record describing snapshot s
  function automatic logic [7:0] meta_rec_byte(input logic [3:0] idx, input meta_snap_t s,
                                               input logic eol_crlf);
    logic [7:0] b;
    b = 8'h00;
    if (s.valid) begin
      case (idx)
        4'd0:    b = ASC_V;
        4'd1:    b = ASC_0 + {5'd0, s.brand};
        4'd2:    b = ASC_0 + {7'd0, s.issuer[4]};
        4'd3:    b = nib2hex(s.issuer[3:0]);
        4'd4:    b = ASC_0 + {6'd0, s.type_id};
        4'd5:    b = s.hit ? ASC_H : ASC_M;
        4'd6:    b = eol_crlf ? ASC_CR : ASC_LF;
        4'd7:    b = ASC_LF;
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        4'd0:    b = ASC_I;
        4'd1:    b = eol_crlf ? ASC_CR : ASC_LF;
        4'd2:    b = ASC_LF;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/meta_report_tx.sv
// Card-metadata record transmitter: snapshots one classification result on a
// request pulse and streams it as an ASCII record over a valid/ready byte link.
module meta_report_tx
  import cc_meta_pkg::*;
#(
  parameter bit EOL_CRLF = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        report_req,
  input  logic        meta_valid,
  input  logic        meta_hit,
  input  logic [2:0]  brand_id,
  input  logic [4:0]  issuer_id,
  input  logic [1:0]  type_id,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] rec_count
);

  tx_state_e   state_q, state_d;
  meta_snap_t  snap_q, snap_d;
  logic [3:0]  idx_q, idx_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        overrun_q, overrun_d;
  logic [15:0] rec_count_q, rec_count_d;

  meta_snap_t  req_snap;
  logic        hs;
  logic        last_byte;
  logic        drop;

  // Live classifier result, captured into the snapshot on a request
  always_comb begin
    req_snap         = '0;
    req_snap.valid   = meta_valid;
    req_snap.hit     = meta_hit;
    req_snap.brand   = brand_id;
    req_snap.issuer  = issuer_id;
    req_snap.type_id = type_id;
  end

  assign hs        = tx_valid_q & tx_ready;
  assign last_byte = (idx_q == (meta_rec_len(snap_q, EOL_CRLF) - 4'd1));

  // Next-state logic: record sequencing, drop detection, output byte precompute
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    tx_valid_d  = tx_valid_q;
    rec_count_d = rec_count_q;
    drop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (report_req) begin
          state_d    = ST_SEND;
          snap_d     = req_snap;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      ST_SEND: begin
        tx_valid_d = 1'b1;
        if (hs && last_byte) begin
          rec_count_d = rec_count_q + 16'd1;
          if (report_req) begin
            // Chain the next record straight on, no idle cycle
            snap_d = req_snap;
            idx_d  = 4'd0;
          end else begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + 4'd1;
          end else begin
            idx_d = idx_q;
          end
          drop = report_req;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    // A drop in the same cycle as start keeps the flag set
    if (drop) begin
      overrun_d = 1'b1;
    end else if (start) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    // Byte is computed from the next index so the output can be registered
    if (tx_valid_d) begin
      tx_data_d = meta_rec_byte(idx_d, snap_d, EOL_CRLF);
    end else begin
      tx_data_d = 8'h00;
    end
  end

  // State, snapshot and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      idx_q       <= 4'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
      rec_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
      rec_count_q <= rec_count_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = tx_valid_q;
  assign overrun   = overrun_q;
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_meta_report_tx.sv
// Bench for meta_report_tx: LF and CRLF instances share stimulus; received
// byte streams are compared against records formatted from the field values.
module tb_meta_report_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        report_req;
  logic        meta_valid;
  logic        meta_hit;
  logic [2:0]  brand_id;
  logic [4:0]  issuer_id;
  logic [1:0]  type_id;
  logic        tx_ready;

  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1;
  logic        busy0, busy1;
  logic        overrun0, overrun1;
  logic [15:0] rec_count0, rec_count1;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  string exp0 = "";
  string exp1 = "";

  meta_report_tx #(.EOL_CRLF(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .report_req(report_req),
    .meta_valid(meta_valid), .meta_hit(meta_hit), .brand_id(brand_id),
    .issuer_id(issuer_id), .type_id(type_id), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0),
    .overrun(overrun0), .rec_count(rec_count0)
  );

  meta_report_tx #(.EOL_CRLF(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .report_req(report_req),
    .meta_valid(meta_valid), .meta_hit(meta_hit), .brand_id(brand_id),
    .issuer_id(issuer_id), .type_id(type_id), .tx_data(tx_data1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready), .busy(busy1),
    .overrun(overrun1), .rec_count(rec_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every accepted byte of each instance
  always @(posedge clk) begin
    if (tx_valid0 && tx_ready) q0.push_back(tx_data0);
    if (tx_valid1 && tx_ready) q1.push_back(tx_data1);
  end

  // Reference record text built directly from the field values
  function automatic string rec_str(input bit v, input bit h, input int b, input int i,
                                    input int t, input bit crlf);
    string hx;
    string hm;
    string s;
    hx = "0123456789ABCDEF";
    hm = h ? "H" : "M";
    if (v) s = $sformatf("V%0d%0d%s%0d%s", b, i / 16, hx.substr(i % 16, i % 16), t, hm);
    else   s = "I";
    s = {s, crlf ? "\015\012" : "\012"};
    return s;
  endfunction

  function automatic string q2hex(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[k]) s = {s, $sformatf("%02h", q[k])};
    return s;
  endfunction

  function automatic string s2hex(input string e);
    string s;
    s = "";
    for (int k = 0; k < e.len(); k++) s = {s, $sformatf("%02h", e[k])};
    return s;
  endfunction

  task automatic scramble_meta();
    meta_valid = 1'($urandom_range(0, 1));
    meta_hit   = 1'($urandom_range(0, 1));
    brand_id   = 3'($urandom_range(0, 7));
    issuer_id  = 5'($urandom_range(0, 31));
    type_id    = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_meta(input bit v, input bit h, input logic [2:0] b,
                            input logic [4:0] i, input logic [1:0] t);
    meta_valid = v; meta_hit = h; brand_id = b; issuer_id = i; type_id = t;
  endtask

  // One-cycle request; returns at the negedge where byte 0 should be shown
  task automatic send_req(input bit v, input bit h, input logic [2:0] b,
                          input logic [4:0] i, input logic [1:0] t);
    drive_meta(v, h, b, i, t);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    scramble_meta();
    exp0 = {exp0, rec_str(v, h, int'(b), int'(i), int'(t), 1'b0)};
    exp1 = {exp1, rec_str(v, h, int'(b), int'(i), int'(t), 1'b1)};
  endtask

  task automatic clear_streams();
    q0.delete(); q1.delete(); exp0 = ""; exp1 = "";
  endtask

  // Run until both instances go idle; with stall, randomise tx_ready and
  // require each offered byte to stay put until it is taken
  task automatic wait_idle(input bit stall);
    logic pv0, pv1, pr;
    logic [7:0] pd0, pd1;
    int n;
    pv0 = 1'b0; pv1 = 1'b0; pr = 1'b1; pd0 = 8'h00; pd1 = 8'h00; n = 0;
    while ((tx_valid0 || tx_valid1) && n < 500) begin
      if (pv0 && !pr) begin
        total++;
        if (tx_valid0 !== 1'b1 || tx_data0 !== pd0) begin
          bad++;
          $display("FAIL hold0: valid=%b data=%02h, required valid=1 data=%02h", tx_valid0, tx_data0, pd0);
        end
      end
      if (pv1 && !pr) begin
        total++;
        if (tx_valid1 !== 1'b1 || tx_data1 !== pd1) begin
          bad++;
          $display("FAIL hold1: valid=%b data=%02h, required valid=1 data=%02h", tx_valid1, tx_data1, pd1);
        end
      end
      pv0 = tx_valid0; pd0 = tx_data0; pv1 = tx_valid1; pd1 = tx_data1;
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      pr = tx_ready;
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b1;
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 5;
    if (tx_valid0 !== 1'b0) begin bad++; $display("FAIL rst_valid: %b, required 0", tx_valid0); end
    if (tx_data0 !== 8'h00) begin bad++; $display("FAIL rst_data: %02h, required 00", tx_data0); end
    if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy: %b, required 0", busy0); end
    if (overrun0 !== 1'b0) begin bad++; $display("FAIL rst_overrun: %b, required 0", overrun0); end
    if (rec_count0 !== 16'd0) begin bad++; $display("FAIL rst_count: %0d, required 0", rec_count0); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (tx_valid0 !== 1'b0 || tx_valid1 !== 1'b0) begin
      bad++; $display("FAIL idle_after_rst: valid0=%b valid1=%b, required 0", tx_valid0, tx_valid1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] golden [7];
    golden = '{8'h56, 8'h31, 8'h30, 8'h33, 8'h31, 8'h48, 8'h0A};
    clear_streams();
    tx_ready = 1'b1;
    send_req(1'b1, 1'b1, 3'd1, 5'd3, 2'd1);
    for (int k = 0; k < 7; k++) begin
      total++;
      if (tx_valid0 !== 1'b1 || tx_data0 !== golden[k]) begin
        bad++;
        $display("FAIL basic_byte%0d: valid=%b data=%02h, required valid=1 data=%02h", k, tx_valid0, tx_data0, golden[k]);
      end
      @(negedge clk);
    end
    exp_cnt++;
    total += 2;
    if (tx_valid0 !== 1'b0 || tx_data0 !== 8'h00 || busy0 !== 1'b0) begin
      bad++; $display("FAIL basic_end: valid=%b data=%02h busy=%b, required 0/00/0", tx_valid0, tx_data0, busy0);
    end
    if (rec_count0 !== 16'(exp_cnt)) begin
      bad++; $display("FAIL basic_count: %0d, required %0d", rec_count0, exp_cnt);
    end
    wait_idle(1'b0);
    total++;
    if (q2hex(q1) != s2hex(exp1)) begin
      bad++; $display("FAIL basic_crlf_stream: got %s, required %s", q2hex(q1), s2hex(exp1));
    end
  endtask

  task automatic test_crlf();
    clear_streams();
    send_req(1'b1, 1'b0, 3'($urandom_range(0, 7)), 5'h1A, 2'($urandom_range(0, 3)));
    wait_idle(1'b0);
    exp_cnt++;
    total++;
    if (q1.size() != 8) begin
      bad++; $display("FAIL crlf_len: %0d bytes, required 8", q1.size());
    end else begin
      total += 5;
      if (q1[2] !== 8'h31) begin bad++; $display("FAIL crlf_b2: %02h, required 31", q1[2]); end
      if (q1[3] !== 8'h41) begin bad++; $display("FAIL crlf_b3: %02h, required 41", q1[3]); end
      if (q1[5] !== 8'h4D) begin bad++; $display("FAIL crlf_b5: %02h, required 4d", q1[5]); end
      if (q1[6] !== 8'h0D) begin bad++; $display("FAIL crlf_b6: %02h, required 0d", q1[6]); end
      if (q1[7] !== 8'h0A) begin bad++; $display("FAIL crlf_b7: %02h, required 0a", q1[7]); end
    end
    total += 2;
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL crlf_lf_stream: got %s, required %s", q2hex(q0), s2hex(exp0)); end
    if (q2hex(q1) != s2hex(exp1)) begin bad++; $display("FAIL crlf_stream: got %s, required %s", q2hex(q1), s2hex(exp1)); end
  endtask

  task automatic test_invalid();
    clear_streams();
    send_req(1'b0, 1'b1, 3'd7, 5'd29, 2'd3);
    wait_idle(1'b0);
    exp_cnt++;
    total += 3;
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL invalid_lf: got %s, required %s", q2hex(q0), s2hex(exp0)); end
    if (q2hex(q1) != s2hex(exp1)) begin bad++; $display("FAIL invalid_crlf: got %s, required %s", q2hex(q1), s2hex(exp1)); end
    if (rec_count0 !== 16'(exp_cnt)) begin bad++; $display("FAIL invalid_count: %0d, required %0d", rec_count0, exp_cnt); end
  endtask

  task automatic test_random_stall();
    clear_streams();
    for (int r = 0; r < 10; r++) begin
      send_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      wait_idle(1'b1);
      exp_cnt++;
    end
    total += 3;
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL stall_lf: got %s, required %s", q2hex(q0), s2hex(exp0)); end
    if (q2hex(q1) != s2hex(exp1)) begin bad++; $display("FAIL stall_crlf: got %s, required %s", q2hex(q1), s2hex(exp1)); end
    if (rec_count0 !== 16'(exp_cnt)) begin bad++; $display("FAIL stall_count: %0d, required %0d", rec_count0, exp_cnt); end
  endtask

  task automatic test_overrun();
    bit cv, ch;
    logic [2:0] cb;
    logic [4:0] ci;
    logic [1:0] ct;
    string cs;
    logic [7:0] c0;
    clear_streams();
    tx_ready = 1'b1;
    // Drop mid-record
    send_req(1'b1, 1'b0, 3'd2, 5'd17, 2'd0);
    repeat (2) @(negedge clk);
    scramble_meta();
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    total++;
    if (overrun0 !== 1'b1) begin bad++; $display("FAIL drop_overrun: %b, required 1", overrun0); end
    wait_idle(1'b0);
    exp_cnt++;
    total++;
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL drop_stream: got %s, required %s", q2hex(q0), s2hex(exp0)); end
    // start alone clears
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (overrun0 !== 1'b0) begin bad++; $display("FAIL start_clear: %b, required 0", overrun0); end
    // Request coincident with the last handshake of the LF instance
    send_req(1'b1, 1'b1, 3'd4, 5'd9, 2'd2);
    repeat (6) @(negedge clk);
    cv = 1'($urandom_range(0, 1)); ch = 1'($urandom_range(0, 1));
    cb = 3'($urandom_range(0, 7)); ci = 5'($urandom_range(0, 31)); ct = 2'($urandom_range(0, 3));
    drive_meta(cv, ch, cb, ci, ct);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    scramble_meta();
    cs = rec_str(cv, ch, int'(cb), int'(ci), int'(ct), 1'b0);
    c0 = cs[0];
    exp0 = {exp0, cs};
    total++;
    if (tx_valid0 !== 1'b1 || tx_data0 !== c0) begin
      bad++; $display("FAIL chain_first: valid=%b data=%02h, required valid=1 data=%02h", tx_valid0, tx_data0, c0);
    end
    wait_idle(1'b0);
    exp_cnt += 2;
    total += 3;
    if (overrun0 !== 1'b0) begin bad++; $display("FAIL chain_overrun: %b, required 0", overrun0); end
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL chain_stream: got %s, required %s", q2hex(q0), s2hex(exp0)); end
    if (rec_count0 !== 16'(exp_cnt)) begin bad++; $display("FAIL chain_count: %0d, required %0d", rec_count0, exp_cnt); end
    // start together with a drop: set wins
    send_req(1'b0, 1'b0, 3'd1, 5'd1, 2'd1);
    start = 1'b1;
    report_req = 1'b1;
    @(negedge clk);
    start = 1'b0;
    report_req = 1'b0;
    total++;
    if (overrun0 !== 1'b1) begin bad++; $display("FAIL start_drop: %b, required 1", overrun0); end
    wait_idle(1'b0);
    exp_cnt++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total += 2;
    if (overrun0 !== 1'b0) begin bad++; $display("FAIL start_clear2: %b, required 0", overrun0); end
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL overrun_stream: got %s, required %s", q2hex(q0), s2hex(exp0)); end
  endtask

  task automatic test_reset_mid();
    clear_streams();
    send_req(1'b1, 1'b1, 3'd5, 5'd30, 2'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total += 3;
    if (tx_valid0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL midrst_valid: valid=%b busy=%b, required 0", tx_valid0, busy0); end
    if (tx_data0 !== 8'h00) begin bad++; $display("FAIL midrst_data: %02h, required 00", tx_data0); end
    if (rec_count0 !== 16'd0) begin bad++; $display("FAIL midrst_count: %0d, required 0", rec_count0); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_streams();
    @(negedge clk);
    send_req(1'b1, 1'b0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    wait_idle(1'b0);
    exp_cnt++;
    total += 3;
    if (q2hex(q0) != s2hex(exp0)) begin bad++; $display("FAIL postrst_lf: got %s, required %s", q2hex(q0), s2hex(exp0)); end
    if (q2hex(q1) != s2hex(exp1)) begin bad++; $display("FAIL postrst_crlf: got %s, required %s", q2hex(q1), s2hex(exp1)); end
    if (rec_count0 !== 16'(exp_cnt)) begin bad++; $display("FAIL postrst_count: %0d, required %0d", rec_count0, exp_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    report_req = 1'b0;
    tx_ready = 1'b1;
    drive_meta(1'b0, 1'b0, 3'd0, 5'd0, 2'd0);
    test_reset();
    test_basic();
    test_crlf();
    test_invalid();
    test_random_stall();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/meta_report_tx.md
# meta_report_tx

Transmit side of the card-metadata path. Captures one classification result (valid flag, hit flag, brand/issuer/type IDs) on a request pulse and serialises it as a fixed-format ASCII record over a byte stream with a valid/ready handshake. Sits downstream of the IIN prefix classifier and feeds the host-facing UART/stream TX.

## Interface
- `EOL_CRLF`, default 0: 0 ends each record with LF (0x0A); 1 ends it with CR LF (0x0D 0x0A).
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  new-card pulse; clears `overrun`
- `report_req`  in  1  1-cycle pulse; snapshot `meta_*` inputs and send a record. Integration drives it as `card_done` delayed one cycle.
- `meta_valid`  in  1  classifier published metadata (Luhn passed)
- `meta_hit`  in  1  prefix table matched
- `brand_id`  in  3  brand code
- `issuer_id`  in  5  issuer code
- `type_id`  in  2  type code
- `tx_data`  out  8  record byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  sink accepts byte
- `busy`  out  1  record in flight; equals `tx_valid`
- `overrun`  out  1  sticky; a request was dropped
- `rec_count`  out  16  completed records, wraps at 0xFFFF→0

## Operation
- Valid record (snapshot `meta_valid`=1): 'V', '0'+brand, '0'+issuer[4], hex(issuer[3:0]) using uppercase 'A'–'F', '0'+type, 'H' if hit else 'M', then EOL. Length is 7+`EOL_CRLF`.
- Invalid record (`meta_valid`=0): 'I', then EOL. Length is 2+`EOL_CRLF`. The ID inputs are ignored.
- FSM states:
  - IDLE → SEND on `report_req`. Snapshot registers load and the byte index is set to 0.
  - SEND → IDLE on a handshake of the last byte, unless `report_req` is high in that same cycle. In that case the FSM stays in SEND, loads a new snapshot, and sets the index to 0.
- Handshake: a byte is transferred on a rising edge with `tx_valid`&&`tx_ready`. The index advances by 1 per handshake.
- `tx_data` and `tx_valid` are stable while `tx_valid`&&!`tx_ready`. `tx_valid` is never withdrawn without a handshake.
- `report_req` in SEND, other than in the last-byte-handshake cycle, is dropped and sets `overrun`. The in-flight record is unaffected.
- `start` never aborts an in-flight record. It clears `overrun`. If a set and a clear of `overrun` occur in the same cycle, set wins.
- `rec_count` increments on the handshake of the last byte of each record.
- `tx_data` is 0x00 whenever `tx_valid`=0.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `busy`=0, `overrun`=0, `rec_count`=0, FSM=IDLE, snapshot=0.
- Latency: `report_req` sampled at edge N → `tx_valid`=1 with byte 0 after edge N.
- Throughput: with `tx_ready` held high, one byte per cycle. A 7-byte record occupies exactly 7 cycles. Back-to-back records have no idle gap.
- After the last handshake with no new request, `tx_valid`=0 the following cycle.
- All outputs are registered. There is no combinational path from `tx_ready` to `tx_data`/`tx_valid`.
- `rst_n` asserted mid-record: the record is discarded and all outputs return to reset values immediately. No partial-record resume.

## Structure
- Shared package `cc_meta_pkg`:
  - BRAND_* / ISS_* / TYPE_* codes, also used by the classifier.
  - ASCII constants: 'V', 'I', 'H', 'M', CR, LF.
  - Record-length localparams.
  - Functions `nib2hex(logic [3:0])` and `meta_rec_byte(idx, snapshot, eol_crlf)`.
- No sub-module. A single FSM plus the byte mux from the package function.

## Test plan
- Snapshot valid=1, hit=1, brand=1, issuer=3, type=1, `tx_ready`=1, `EOL_CRLF`=0 → bytes 0x56 0x31 0x30 0x33 0x31 0x48 0x0A on 7 consecutive cycles; `rec_count`=1.
- valid=1, issuer=0x1A, hit=0, `EOL_CRLF`=1 → byte 2 = 0x31, byte 3 = 0x41, byte 5 = 0x4D, ends 0x0D 0x0A; 8 bytes total.
- valid=0 with non-zero IDs → 0x49 0x0A only.
- Random `tx_ready` stalls (~50%) → each byte is held stable until accepted; sequence is identical to the no-stall case.
- `report_req` mid-record → `overrun`=1 and no extra record. `report_req` coincident with the last handshake → second record starts next cycle with no gap. `start` with a drop in the same cycle → `overrun` stays 1. `start` alone → `overrun` clears.
- `rst_n` low at byte 3 → `tx_valid`=0 and `rec_count`=0 immediately. A new request after release sends a full record from byte 0.
